btb_predictor: RTL

- Parametrised, direct-mapped branch target buffer (BTB) with an optional per-entry 2-bit saturating direction counter.
- Sits beside the fetch stage.
  - Lookup path: combinational prediction of next PC from the current fetch PC.
  - Update path: sequential, driven by the execute stage when a branch resolves.
- Replaces the fixed 4-entry always-taken table. Adds:
  - configurable depth;
  - direction prediction;
  - bulk invalidate;
  - a mispredict statistics counter.

---
 rtl/btb_predictor_pkg.sv | 26 ++
 rtl/btb_predictor_if.sv | 33 +++
 rtl/btb_predictor_sat_counter2.sv | 22 ++
 rtl/btb_predictor.sv | 94 +++++++++
 4 files changed

// File: rtl/btb_predictor_pkg.sv
// Shared types for the branch target buffer: direction counter encoding,
// table entry layout and the PC-to-tag split helper.
package btb_predictor_pkg;

    typedef logic [1:0] btb_ctr_t;

    localparam btb_ctr_t CTR_SNT = 2'b00;
    localparam btb_ctr_t CTR_WNT = 2'b01;
    localparam btb_ctr_t CTR_WT  = 2'b10;
    localparam btb_ctr_t CTR_ST  = 2'b11;

    localparam int TAG_MAX_W = 30;

    // Tag is stored right-aligned; bits above the configured tag width stay zero
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        btb_ctr_t             ctr;
    } btbentry_t;

    function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [29:0] waddr, input int idx_w);
        return waddr >> idx_w;
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch/execute-side signal bundle of the branch predictor.
interface btb_predictor_if;

    logic [31:0] curr_pc;
    logic        btb_hit;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic        invalidate_all;
    logic [31:0] mispredict_count;

    modport bp (
        input  curr_pc, update_en, update_pc, update_taken, update_target,
               update_mispredict, invalidate_all,
        output btb_hit, pred_taken, pred_pc, mispredict_count
    );

    modport fetch (
        output curr_pc,
        input  btb_hit, pred_taken, pred_pc
    );

    modport ex (
        output update_en, update_pc, update_taken, update_target,
               update_mispredict, invalidate_all,
        input  mispredict_count
    );

endinterface

// File: rtl/btb_predictor_sat_counter2.sv
// Two-bit saturating up/down counter next-value logic, shared by predictor variants.
module sat_counter2
    import btb_predictor_pkg::*;
(
    input  btb_ctr_t ctr,
    input  logic     taken,
    output btb_ctr_t ctr_next
);

    // Step toward the resolved direction, holding at either end
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
            else               ctr_next = ctr;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
            else                ctr_next = ctr;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with optional 2-bit direction counters.
// Lookup is combinational from curr_pc; table updates and stats are registered.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int       ENTRIES  = 4,
    parameter int       MODE     = 1,
    parameter btb_ctr_t CTR_INIT = CTR_WT
) (
    input  logic        CLK,
    input  logic        nRST,
    btb_predictor_if.bp bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam btbentry_t RST_ENTRY = '{valid: 1'b0, tag: 30'd0, target: 32'd0, ctr: CTR_WNT};

    btbentry_t        table_r [ENTRIES];
    logic [31:0]      mispredict_count_r;
    logic [IDX_W-1:0] lk_idx_s;
    logic [IDX_W-1:0] up_idx_s;
    logic [29:0]      up_tag_s;
    btbentry_t        lk_entry_s;
    btbentry_t        up_entry_s;
    logic             lk_hit_s;
    logic             lk_dir_s;
    logic             lk_taken_s;
    logic [31:0]      lk_next_pc_s;
    logic             uhit_s;
    btb_ctr_t         ctr_next_s;
    logic             unused_s;

    assign lk_idx_s = bp.curr_pc[IDX_W+1:2];
    assign up_idx_s = bp.update_pc[IDX_W+1:2];
    assign up_tag_s = pc_tag(bp.update_pc[31:2], IDX_W);

    // Lookup reads the pre-update table; a same-cycle write shows up next cycle
    always_comb begin
        lk_entry_s = table_r[lk_idx_s];
        lk_hit_s   = lk_entry_s.valid && (lk_entry_s.tag == pc_tag(bp.curr_pc[31:2], IDX_W));
        if (MODE == 0) lk_dir_s = 1'b1;
        else           lk_dir_s = lk_entry_s.ctr[1];
        lk_taken_s = lk_hit_s && lk_dir_s;
        if (lk_taken_s) lk_next_pc_s = lk_entry_s.target;
        else            lk_next_pc_s = bp.curr_pc + 32'd4;
    end

    // Tag check for the entry the resolving branch maps to
    always_comb begin
        up_entry_s = table_r[up_idx_s];
        uhit_s     = up_entry_s.valid && (up_entry_s.tag == up_tag_s);
    end

    sat_counter2 u_ctr (
        .ctr      (up_entry_s.ctr),
        .taken    (bp.update_taken),
        .ctr_next (ctr_next_s)
    );

    // Table write port: invalidate wins over update; not-taken misses never allocate
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) table_r[i] <= RST_ENTRY;
        end else if (bp.invalidate_all) begin
            for (int i = 0; i < ENTRIES; i++) table_r[i].valid <= 1'b0;
        end else if (bp.update_en) begin
            if (uhit_s) begin
                table_r[up_idx_s].ctr <= ctr_next_s;
                if (bp.update_taken) table_r[up_idx_s].target <= bp.update_target;
            end else if (bp.update_taken) begin
                table_r[up_idx_s] <= '{valid: 1'b1, tag: up_tag_s,
                                       target: bp.update_target, ctr: CTR_INIT};
            end
        end
    end

    // Saturating mispredict statistics, untouched by invalidate_all
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mispredict_count_r <= 32'd0;
        end else if (bp.update_en && bp.update_mispredict &&
                     (mispredict_count_r != 32'hFFFF_FFFF)) begin
            mispredict_count_r <= mispredict_count_r + 32'd1;
        end
    end

    assign bp.btb_hit          = lk_hit_s;
    assign bp.pred_taken       = lk_taken_s;
    assign bp.pred_pc          = lk_next_pc_s;
    assign bp.mispredict_count = mispredict_count_r;

    assign unused_s = ^{bp.update_pc[1:0], lk_entry_s.ctr, up_entry_s.target};

endmodule
